// File: rtl/opacc_pkg.sv
// opacc_pkg: types and helpers shared by the opacc_ctrl codebase slice.
//   opacc_state_e  : controller phase (IDLE, LOAD, MAC, DRAIN)
//   row_cnt_width  : width of a counter that can hold 0..ml
package opacc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MAC,
        DRAIN
    } opacc_state_e;

    function automatic int unsigned row_cnt_width(input int unsigned ml);
        return $clog2(ml + 1);
    endfunction

endpackage

// File: rtl/opacc.sv
// opacc: ML x VL outer-product accumulator tile.
//   clk, reset : clock, asynchronous active-high reset (clears all rows)
//   shift      : row[0] <= vi_c, row[i] <= row[i-1]; row ML-1 falls out
//   update     : C[i][j] += vi_a[i] * vi_b[j] (modulo 2^XLEN)
//   vi_a       : ML elements, vi_b / vi_c : VL elements (element n at [n*XLEN +: XLEN])
//   row_out    : current contents of row ML-1
// shift has priority over update; the controller never asserts both.
module opacc #(
    parameter int unsigned VL   = 4,
    parameter int unsigned ML   = 4,
    parameter int unsigned XLEN = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               shift,
    input  logic               update,
    input  logic [ML*XLEN-1:0] vi_a,
    input  logic [VL*XLEN-1:0] vi_b,
    input  logic [VL*XLEN-1:0] vi_c,
    output logic [VL*XLEN-1:0] row_out
);

    logic [VL*XLEN-1:0] acc_q [ML];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < ML; i++) begin
                acc_q[i] <= '0;
            end
        end else if (shift) begin
            acc_q[0] <= vi_c;
            for (int unsigned i = 1; i < ML; i++) begin
                acc_q[i] <= acc_q[i-1];
            end
        end else if (update) begin
            for (int unsigned i = 0; i < ML; i++) begin
                for (int unsigned j = 0; j < VL; j++) begin
                    acc_q[i][j*XLEN +: XLEN] <= acc_q[i][j*XLEN +: XLEN]
                        + vi_a[i*XLEN +: XLEN] * vi_b[j*XLEN +: XLEN];
                end
            end
        end
    end

    assign row_out = acc_q[ML-1];

endmodule

// File: rtl/opacc_ctrl.sv
// opacc_ctrl: job sequencer for one opacc tile (instance u_acc).
//   Job: optional C preload (ML rows from c_in), k rank-1 updates from a/b,
//   then ML-row drain on c_out (row ML-1 first); drain leaves the tile zeroed.
// Ports:
//   clk, reset                       clock, async active-high reset (also resets tile)
//   cmd_valid/cmd_ready/cmd_k/cmd_load_c   job request (ready only in IDLE)
//   c_in_valid/c_in_ready/c_in_data  preload rows (ready only in LOAD)
//   ab_valid_i/ab_ready_o/a_data/b_data    operand pairs (ready only in MAC)
//   c_out_valid/c_out_ready/c_out_data/c_out_last   result rows (DRAIN only)
//   done                             pulse on the final drain handshake
// Optional macro OPACC_CTRL_PERF_EN adds perf_mac_cycles / perf_stall_cycles
// (MAC cycles and MAC cycles without ab_valid_i; cleared per job, saturating).
module opacc_ctrl
    import opacc_pkg::*;
#(
    parameter int unsigned VL   = 4,
    parameter int unsigned ML   = 4,
    parameter int unsigned XLEN = 64,
    parameter int unsigned KW   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [KW-1:0]      cmd_k,
    input  logic               cmd_load_c,
    input  logic               c_in_valid,
    output logic               c_in_ready,
    input  logic [VL*XLEN-1:0] c_in_data,
    input  logic               ab_valid_i,
    output logic               ab_ready_o,
    input  logic [ML*XLEN-1:0] a_data,
    input  logic [VL*XLEN-1:0] b_data,
    output logic               c_out_valid,
    input  logic               c_out_ready,
    output logic [VL*XLEN-1:0] c_out_data,
    output logic               c_out_last,
    output logic               done
`ifdef OPACC_CTRL_PERF_EN
    ,
    output logic [31:0]        perf_mac_cycles,
    output logic [31:0]        perf_stall_cycles
`endif
);

    localparam int unsigned     CW       = row_cnt_width(ML);
    localparam logic [CW-1:0]   LAST_ROW = CW'(ML - 1);

    if (ML != VL) begin : g_shape_check
        $error("opacc_ctrl: ML must equal VL");
    end

    opacc_state_e       state_q;
    logic [KW-1:0]      k_q;
    logic [KW-1:0]      beat_q;
    logic [CW-1:0]      row_q;

    logic               cmd_hs, c_in_hs, ab_hs, c_out_hs;
    logic               acc_shift, acc_update;
    logic [VL*XLEN-1:0] acc_vi_c;

    assign cmd_hs   = cmd_valid & cmd_ready;
    assign c_in_hs  = c_in_valid & c_in_ready;
    assign ab_hs    = ab_valid_i & ab_ready_o;
    assign c_out_hs = c_out_valid & c_out_ready;

    // Drain shifts zeros in, so the tile is clear when the job ends.
    assign acc_shift  = c_in_hs | c_out_hs;
    assign acc_update = ab_hs;
    assign acc_vi_c   = c_in_hs ? c_in_data : '0;

    assign done = c_out_hs & c_out_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            beat_q      <= '0;
            row_q       <= '0;
            cmd_ready   <= 1'b1;
            c_in_ready  <= 1'b0;
            ab_ready_o  <= 1'b0;
            c_out_valid <= 1'b0;
            c_out_last  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_hs) begin
                        k_q       <= cmd_k;
                        beat_q    <= '0;
                        row_q     <= '0;
                        cmd_ready <= 1'b0;
                        if (cmd_load_c) begin
                            state_q    <= LOAD;
                            c_in_ready <= 1'b1;
                        end else if (cmd_k == '0) begin
                            state_q     <= DRAIN;
                            c_out_valid <= 1'b1;
                            c_out_last  <= (ML == 1);
                        end else begin
                            state_q    <= MAC;
                            ab_ready_o <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (c_in_hs) begin
                        if (row_q == LAST_ROW) begin
                            row_q      <= '0;
                            c_in_ready <= 1'b0;
                            if (k_q == '0) begin
                                state_q     <= DRAIN;
                                c_out_valid <= 1'b1;
                                c_out_last  <= (ML == 1);
                            end else begin
                                state_q    <= MAC;
                                ab_ready_o <= 1'b1;
                            end
                        end else begin
                            row_q <= row_q + CW'(1);
                        end
                    end
                end
                MAC: begin
                    if (ab_hs) begin
                        if (beat_q == k_q - KW'(1)) begin
                            state_q     <= DRAIN;
                            ab_ready_o  <= 1'b0;
                            c_out_valid <= 1'b1;
                            c_out_last  <= (ML == 1);
                        end else begin
                            beat_q <= beat_q + KW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (c_out_hs) begin
                        if (row_q == LAST_ROW) begin
                            state_q     <= IDLE;
                            row_q       <= '0;
                            c_out_valid <= 1'b0;
                            c_out_last  <= 1'b0;
                            cmd_ready   <= 1'b1;
                        end else begin
                            row_q      <= row_q + CW'(1);
                            c_out_last <= (row_q == LAST_ROW - CW'(1));
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef OPACC_CTRL_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_mac_cycles   <= '0;
            perf_stall_cycles <= '0;
        end else if (cmd_hs) begin
            perf_mac_cycles   <= '0;
            perf_stall_cycles <= '0;
        end else if (state_q == MAC) begin
            if (perf_mac_cycles != '1) begin
                perf_mac_cycles <= perf_mac_cycles + 32'd1;
            end
            if (!ab_valid_i && perf_stall_cycles != '1) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

    opacc #(
        .VL  (VL),
        .ML  (ML),
        .XLEN(XLEN)
    ) u_acc (
        .clk    (clk),
        .reset  (reset),
        .shift  (acc_shift),
        .update (acc_update),
        .vi_a   (a_data),
        .vi_b   (b_data),
        .vi_c   (acc_vi_c),
        .row_out(c_out_data)
    );

endmodule

// File: tb/tb_opacc_ctrl.sv
// tb_opacc_ctrl: directed + randomized job sequence for opacc_ctrl (ML=VL=4, XLEN=64).
// Reference: a 4x4 matrix of 64-bit values updated by C += a*b^T per beat;
// preload beat j fills row ML-1-j, drain beat j carries row ML-1-j.
// Build with OPACC_CTRL_PERF_EN to also cover the perf counters.
module tb_opacc_ctrl;

    localparam int unsigned VL   = 4;
    localparam int unsigned ML   = 4;
    localparam int unsigned XLEN = 64;
    localparam int unsigned KW   = 16;
    localparam int unsigned RW   = VL * XLEN;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmd_valid, cmd_ready, cmd_load_c;
    logic [KW-1:0]   cmd_k;
    logic            c_in_valid, c_in_ready;
    logic [RW-1:0]   c_in_data;
    logic            ab_valid_i, ab_ready_o;
    logic [RW-1:0]   a_data, b_data;
    logic            c_out_valid, c_out_ready, c_out_last, done;
    logic [RW-1:0]   c_out_data;
`ifdef OPACC_CTRL_PERF_EN
    logic [31:0]     perf_mac_cycles, perf_stall_cycles;
`endif

    opacc_ctrl #(
        .VL  (VL),
        .ML  (ML),
        .XLEN(XLEN),
        .KW  (KW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_k      (cmd_k),
        .cmd_load_c (cmd_load_c),
        .c_in_valid (c_in_valid),
        .c_in_ready (c_in_ready),
        .c_in_data  (c_in_data),
        .ab_valid_i (ab_valid_i),
        .ab_ready_o (ab_ready_o),
        .a_data     (a_data),
        .b_data     (b_data),
        .c_out_valid(c_out_valid),
        .c_out_ready(c_out_ready),
        .c_out_data (c_out_data),
        .c_out_last (c_out_last),
        .done       (done)
`ifdef OPACC_CTRL_PERF_EN
        ,
        .perf_mac_cycles  (perf_mac_cycles),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int exp_mac    = 0;
    int exp_stall  = 0;

    longint unsigned mdl [ML][VL];

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW-1:0] row_of(input int unsigned r);
        logic [RW-1:0] v;
        for (int unsigned j = 0; j < VL; j++) v[j*XLEN +: XLEN] = mdl[r][j];
        return v;
    endfunction

    function automatic logic [RW-1:0] splat(input longint unsigned x);
        logic [RW-1:0] v;
        for (int unsigned j = 0; j < VL; j++) v[j*XLEN +: XLEN] = x;
        return v;
    endfunction

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] v;
        for (int unsigned j = 0; j < VL; j++) v[j*XLEN +: XLEN] = {$urandom(), $urandom()};
        return v;
    endfunction

    task automatic clear_model();
        for (int unsigned i = 0; i < ML; i++)
            for (int unsigned j = 0; j < VL; j++) mdl[i][j] = 0;
    endtask

    task automatic run_cmd(input int k, input bit load_c);
        cmd_k      = KW'(k);
        cmd_load_c = load_c;
        cmd_valid  = 1'b1;
        for (int n = 0; n < 50 && !cmd_ready; n++) step();
        check("cmd_ready_wait", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
        exp_mac   = 0;
        exp_stall = 0;
        check("cmd_ready_after_accept", cmd_ready, 1'b0);
        if (load_c)      check("c_in_ready_after_cmd", c_in_ready, 1'b1);
        else if (k == 0) check("c_out_valid_after_cmd", c_out_valid, 1'b1);
        else             check("ab_ready_after_cmd", ab_ready_o, 1'b1);
    endtask

    task automatic load_row(input logic [RW-1:0] data, input int unsigned j, input int gap);
        c_in_valid = 1'b0;
        for (int n = 0; n < gap; n++) step();
        c_in_valid = 1'b1;
        c_in_data  = data;
        for (int n = 0; n < 50 && !c_in_ready; n++) step();
        check("c_in_ready", c_in_ready, 1'b1);
        step();
        c_in_valid = 1'b0;
        for (int unsigned e = 0; e < VL; e++) mdl[ML-1-j][e] = data[e*XLEN +: XLEN];
    endtask

    task automatic mac_beat(input logic [RW-1:0] a, input logic [RW-1:0] b, input int gap);
        ab_valid_i = 1'b0;
        for (int n = 0; n < gap; n++) begin
            check("ab_ready_gap", ab_ready_o, 1'b1);
            step();
        end
        ab_valid_i = 1'b1;
        a_data     = a;
        b_data     = b;
        check("ab_ready", ab_ready_o, 1'b1);
        step();
        ab_valid_i = 1'b0;
        exp_mac   += gap + 1;
        exp_stall += gap;
        for (int unsigned i = 0; i < ML; i++)
            for (int unsigned j = 0; j < VL; j++)
                mdl[i][j] += longint'(a[i*XLEN +: XLEN]) * longint'(b[j*XLEN +: XLEN]);
    endtask

    // use_pat: bit n of pat is c_out_ready in drain cycle n; otherwise random.
    task automatic drain(input bit use_pat, input logic [31:0] pat);
        int j;
        j = 0;
        for (int n = 0; n < 50 && !c_out_valid; n++) step();
        for (int n = 0; n < 200 && j < int'(ML); n++) begin
            c_out_ready = use_pat ? pat[n % 32] : ($urandom_range(0, 2) != 0);
            #1;
            check("c_out_valid", c_out_valid, 1'b1);
            check("c_out_data", c_out_data, row_of(ML - 1 - j));
            check("c_out_last", c_out_last, j == int'(ML) - 1);
            check("done", done, c_out_ready && j == int'(ML) - 1);
            check("cmd_ready_in_drain", cmd_ready, 1'b0);
            @(posedge clk);
            #1;
            if (c_out_ready) j++;
        end
        c_out_ready = 1'b0;
        check("drain_beats", j, ML);
        check("c_out_valid_after_drain", c_out_valid, 1'b0);
        check("done_after_drain", done, 1'b0);
        check("cmd_ready_after_drain", cmd_ready, 1'b1);
`ifdef OPACC_CTRL_PERF_EN
        check("perf_mac", perf_mac_cycles, exp_mac);
        check("perf_stall", perf_stall_cycles, exp_stall);
`endif
        clear_model();
    endtask

    task automatic random_job();
        int  k;
        bit  load_c;
        k      = $urandom_range(0, 4);
        load_c = $urandom_range(0, 1) != 0;
        run_cmd(k, load_c);
        if (load_c) begin
            for (int unsigned j = 0; j < ML; j++) load_row(rand_row(), j, $urandom_range(0, 1));
            if (k == 0) check("load_to_drain", c_out_valid, 1'b1);
            else        check("load_to_mac", ab_ready_o, 1'b1);
        end
        for (int i = 0; i < k; i++) mac_beat(rand_row(), rand_row(), $urandom_range(0, 2));
        if (k > 0) check("mac_to_drain_latency", c_out_valid, 1'b1);
        drain(1'b0, 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_k       = '0;
        cmd_load_c  = 1'b0;
        c_in_valid  = 1'b0;
        c_in_data   = '0;
        ab_valid_i  = 1'b0;
        a_data      = '0;
        b_data      = '0;
        c_out_ready = 1'b0;
        clear_model();
        repeat (3) step();

        // Reset state
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_c_in_ready", c_in_ready, 1'b0);
        check("rst_ab_ready", ab_ready_o, 1'b0);
        check("rst_c_out_valid", c_out_valid, 1'b0);
        check("rst_c_out_last", c_out_last, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_c_out_data", c_out_data, '0);
`ifdef OPACC_CTRL_PERF_EN
        check("rst_perf_mac", perf_mac_cycles, 32'd0);
        check("rst_perf_stall", perf_stall_cycles, 32'd0);
`endif
        reset = 1'b0;
        step();

        // k=1, no preload: rows out 4,3,2,1
        run_cmd(1, 1'b0);
        mac_beat({64'd4, 64'd3, 64'd2, 64'd1}, splat(64'd1), 0);
        check("t1_latency", c_out_valid, 1'b1);
        check("t1_first_row", c_out_data, splat(64'd4));
        drain(1'b0, 32'd0);

        // k=0 with preload 10,20,30,40: out in the same order
        run_cmd(0, 1'b1);
        for (int unsigned j = 0; j < ML; j++) load_row(splat(64'(10 * (j + 1))), j, 0);
        check("t2_load_to_drain", c_out_valid, 1'b1);
        check("t2_first_row", c_out_data, splat(64'd10));
        drain(1'b0, 32'd0);

        // Tile must be zero after drain
        run_cmd(0, 1'b0);
        drain(1'b1, 32'hFFFF_FFFF);

        // k=3 with gaps 1-0-0-1-1; drain ready 0,1,0,0,1,1,1
        run_cmd(3, 1'b0);
        mac_beat(splat(64'd1), splat(64'd2), 0);
        mac_beat(splat(64'd1), splat(64'd2), 2);
        mac_beat(splat(64'd1), splat(64'd2), 0);
        check("t3_first_row", c_out_data, splat(64'd6));
        drain(1'b1, 32'b1110010);

        // Async reset mid-MAC discards partial work
        run_cmd(3, 1'b0);
        mac_beat(rand_row(), rand_row(), 0);
        mac_beat(rand_row(), rand_row(), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_cmd_ready", cmd_ready, 1'b1);
        check("mid_rst_ab_ready", ab_ready_o, 1'b0);
        check("mid_rst_c_in_ready", c_in_ready, 1'b0);
        check("mid_rst_c_out_valid", c_out_valid, 1'b0);
        check("mid_rst_c_out_data", c_out_data, '0);
        clear_model();
        step();
        reset = 1'b0;
        step();
        run_cmd(1, 1'b0);
        mac_beat(rand_row(), rand_row(), 0);
        drain(1'b0, 32'd0);

        // cmd_valid held high across two jobs; cmd_k change mid-job ignored
        cmd_k      = KW'(1);
        cmd_load_c = 1'b0;
        cmd_valid  = 1'b1;
        for (int n = 0; n < 50 && !cmd_ready; n++) step();
        step();
        exp_mac   = 0;
        exp_stall = 0;
        check("hold_accept1", cmd_ready, 1'b0);
        cmd_k = KW'(3);
        mac_beat(rand_row(), rand_row(), 0);
        check("hold_k_latched", c_out_valid, 1'b1);
        drain(1'b0, 32'd0);
        step();
        exp_mac   = 0;
        exp_stall = 0;
        cmd_valid = 1'b0;
        check("hold_accept2", cmd_ready, 1'b0);
        check("hold_job2_mac", ab_ready_o, 1'b1);
        for (int i = 0; i < 3; i++) mac_beat(rand_row(), rand_row(), $urandom_range(0, 1));
        drain(1'b0, 32'd0);

        // Randomized jobs
        for (int t = 0; t < 8; t++) random_job();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
